// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - PC, in-order fetch request issue and response FIFO toward decode (option: IFETCH_MISALIGN_CHECK_EN)
module ifetch_queue #(
  parameter int              FIFO_DEPTH = 4,
  parameter int              ALEN       = 32,
  parameter int              ILEN       = 32,
  parameter logic [ALEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [ALEN-1:0] flush_target,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [ALEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [ILEN-1:0] mem_resp_data,
  input  logic            mem_resp_error,
  output logic [ILEN-1:0] instruction,
  output logic [ALEN-1:0] instruction_addr,
  output logic [ALEN-1:0] instruction_next_addr,
  output logic            ifetch_exception,
  output logic            stall_next,
  input  logic            next_stalled
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ALEN-1:0]        pc;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          drop;
  logic [CW-1:0]          count;
  logic [CW:0]            occupancy;

  logic [ILEN-1:0]        fifo_data [FIFO_DEPTH];
  logic [ALEN-1:0]        fifo_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_err;
  logic [ALEN-1:0]        aq_addr   [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          aq_rd;
  logic [AW-1:0]          aq_wr;

  logic                   pop;
  logic                   accept;
  logic                   push;
  logic                   misalign;
  logic [ALEN-1:0]        target_aligned;

  assign stall_next     = (count == '0);
  assign pop            = !stall_next && !next_stalled;
  assign accept         = mem_req_valid && mem_req_ready;
  // A response is kept only outside a flush and once all stale beats are drained
  assign push           = mem_resp_valid && !flush && (drop == '0);
  assign target_aligned = {flush_target[ALEN-1:2], 2'b00};

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misalign = flush && (flush_target[1:0] != 2'b00);
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^flush_target[1:0];
  assign misalign           = 1'b0;
`endif

  // Buffered entries plus in-flight requests, after this cycle's pop frees a slot
  assign occupancy = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};

  assign mem_req_addr          = pc;
  assign instruction           = fifo_data[rd_ptr];
  assign instruction_addr      = fifo_addr[rd_ptr];
  assign instruction_next_addr = fifo_addr[rd_ptr] + ALEN'(4);
  assign ifetch_exception      = !stall_next && fifo_err[rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next state: flush always restarts (or halts on a bad target), a pushed fault halts
  always_comb begin
    state_nxt = state;
    if (flush)                        state_nxt = misalign ? ST_HALT : ST_RUN;
    else if (push && mem_resp_error)  state_nxt = ST_HALT;
  end

  // Request issue: only while running, never in a flush cycle, and only with a free slot
  always_comb begin
    mem_req_valid = 1'b0;
    if (!rst && state == ST_RUN && !flush && occupancy < (CW+1)'(FIFO_DEPTH))
      mem_req_valid = 1'b1;
  end

  // PC, counters and queue pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      aq_rd    <= '0;
      aq_wr    <= '0;
    end else if (flush) begin
      pc       <= target_aligned;
      inflight <= inflight - CW'(mem_resp_valid);
      drop     <= inflight - CW'(mem_resp_valid);
      rd_ptr   <= '0;
      aq_rd    <= '0;
      aq_wr    <= '0;
      wr_ptr   <= misalign ? AW'(1) : '0;
      count    <= misalign ? CW'(1) : '0;
    end else begin
      if (accept) begin
        pc    <= pc + ALEN'(4);
        aq_wr <= aq_wr + AW'(1);
      end
      inflight <= inflight + CW'(accept) - CW'(mem_resp_valid);
      if (mem_resp_valid && drop != '0) drop <= drop - CW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        aq_rd  <= aq_rd + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage: responses land with their recorded request address
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_err <= '0;
    end else if (misalign) begin
      fifo_data[0] <= '0;
      fifo_addr[0] <= flush_target;
      fifo_err[0]  <= 1'b1;
    end else if (push) begin
      fifo_data[wr_ptr] <= mem_resp_data;
      fifo_addr[wr_ptr] <= aq_addr[aq_rd];
      fifo_err[wr_ptr]  <= mem_resp_error;
    end
  end

  // Address queue: request address captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) aq_addr[aq_wr] <= pc;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized scoreboard bench for ifetch_queue
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_target = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_error = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instruction_addr;
  logic [31:0] instruction_next_addr;
  logic        ifetch_exception;
  logic        stall_next;
  logic        next_stalled = 1'b0;

  always #5 clk = ~clk;

  ifetch_queue #(.FIFO_DEPTH(DEPTH), .ALEN(32), .ILEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_target(flush_target),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_error(mem_resp_error),
    .instruction(instruction), .instruction_addr(instruction_addr),
    .instruction_next_addr(instruction_next_addr), .ifetch_exception(ifetch_exception),
    .stall_next(stall_next), .next_stalled(next_stalled)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  req_t        pending[$];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          epoch = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          mode = 0;
  bit          halted = 0;
  bit          started = 0;
  bit          want_rst = 1;
  logic [31:0] pc_m = RESET_PC;

  bit          r_rst, r_flush, r_resp, acc;
  logic [31:0] r_tgt, acc_addr;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Apply the previous cycle's events to the reference model
  task automatic commit();
    req_t r;
    exp_t e;
    if (r_rst) begin
      pending.delete();
      exp_q.delete();
      halted = 0;
      pc_m = RESET_PC;
      last_due = 0;
      epoch++;
      return;
    end
    if (r_resp) begin
      r = pending.pop_front();
      if (r.epoch == epoch && !r_flush) begin
        e.addr = r.addr; e.data = r.data; e.err = r.err; e.chk_data = 1'b1;
        exp_q.push_back(e);
        if (r.err) halted = 1;
      end
    end
    if (acc) begin
      r.addr  = acc_addr;
      r.data  = $urandom;
      r.err   = (mode == 2) && ($urandom_range(0, 23) == 0);
      r.epoch = epoch;
      r.due   = cyc + ((mode == 2) ? $urandom_range(1, 3) : 1);
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      pending.push_back(r);
      pc_m = pc_m + 32'd4;
    end
    if (r_flush) begin
      exp_q.delete();
      epoch++;
      halted = 0;
      pc_m = r_tgt & ~32'h3;
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (r_tgt[1:0] != 2'b00) begin
        e.addr = r_tgt; e.data = '0; e.err = 1'b1; e.chk_data = 1'b0;
        exp_q.push_back(e);
        halted = 1;
      end
`endif
    end
  endtask

  task automatic drive();
    rst            = want_rst;
    mem_req_ready  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    next_stalled   = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
    flush          = !want_rst && (mode == 2) && ($urandom_range(0, 15) == 0);
    flush_target   = {$urandom_range(0, 4095), 2'b00} << 2;
    if ($urandom_range(0, 3) == 0) flush_target[1:0] = 2'($urandom_range(1, 3));
    mem_resp_valid = !want_rst && pending.size() != 0 && pending[0].due <= cyc;
    mem_resp_data  = mem_resp_valid ? pending[0].data : 32'hDEAD_BEEF;
    mem_resp_error = mem_resp_valid ? pending[0].err : 1'b0;
    r_rst   = want_rst;
    r_flush = flush;
    r_tgt   = flush_target;
    r_resp  = mem_resp_valid;
  endtask

  task automatic run(int ncyc, int m);
    mode = m;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      commit();
      cyc++;
      #1;
      drive();
      @(negedge clk);
      acc      = mem_req_valid && mem_req_ready;
      acc_addr = mem_req_addr;
    end
  endtask

  // Monitor: compare head, stall and request issue against the model every cycle
  always @(negedge clk) begin
    bit pop_m;
    int occ;
    exp_t e;
    if (started && !rst) begin
      pop_m = (exp_q.size() != 0) && !next_stalled;
      chk("stall_next", 64'(stall_next), 64'(exp_q.size() == 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("head_addr", 64'(instruction_addr), 64'(e.addr));
        chk("head_next_addr", 64'(instruction_next_addr), 64'(e.addr + 32'd4));
        chk("head_exception", 64'(ifetch_exception), 64'(e.err));
        if (e.chk_data) chk("head_data", 64'(instruction), 64'(e.data));
      end
      occ = pending.size() + exp_q.size() - int'(pop_m);
      chk("mem_req_valid", 64'(mem_req_valid), 64'(!halted && !flush && occ < DEPTH));
      if (mem_req_valid) chk("mem_req_addr", 64'(mem_req_addr), 64'(pc_m));
      if (pop_m && !flush) void'(exp_q.pop_front());
    end
  end

  initial begin
    want_rst = 1;
    run(3, 0);
    chk("reset_stall_next", 64'(stall_next), 64'd1);
    chk("reset_req_valid", 64'(mem_req_valid), 64'd0);
    chk("reset_req_addr", 64'(mem_req_addr), 64'(RESET_PC));
    chk("reset_exception", 64'(ifetch_exception), 64'd0);
    started  = 1;
    want_rst = 0;
    run(20, 0);
    run(6, 1);
    run(15, 0);
    run(1500, 2);
    want_rst = 1;
    run(2, 2);
    want_rst = 0;
    run(1500, 2);
    run(30, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage feeding the decode stage's skid-buffered input. Holds the PC, issues in-order 32-bit fetch requests to the instruction memory port, and queues returned words in a small FIFO. Presents one instruction per cycle to decode with its address, next address and fetch-fault flag. Discards stale responses after a pipeline flush.

## Interface
- `FIFO_DEPTH`, default 4: response FIFO entries; also the cap on outstanding requests plus buffered entries. Power of two, ≥2.
- `RESET_PC`, default `'h0`: PC loaded on reset; `ALEN` bits.
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-high.
- `flush` in, 1: redirect; discard all queued and in-flight fetches.
- `flush_target` in, `ALEN`: new PC, sampled when `flush`=1.
- `mem_req_valid` out, 1: fetch request.
- `mem_req_ready` in, 1: memory accepts the request.
- `mem_req_addr` out, `ALEN`: fetch address, word-aligned.
- `mem_resp_valid` in, 1: response beat. Responses are in order; the memory never stalls a response.
- `mem_resp_data` in, `ILEN`: fetched word.
- `mem_resp_error` in, 1: access fault on this response.
- `instruction` out, `ILEN`: FIFO head word.
- `instruction_addr` out, `ALEN`: address of the head word.
- `instruction_next_addr` out, `ALEN`: `instruction_addr + 4`, wrapping modulo 2^`ALEN`.
- `ifetch_exception` out, 1: the head entry is a fault.
- `stall_next` out, 1: no valid head entry (FIFO empty). Drives decode's `prev_stalled`.
- `next_stalled` in, 1: decode cannot accept. Driven by decode's `stall_prev`.

## Operation
- **Transfer:** an item transfers when `!stall_next && !next_stalled` (the pop). Head outputs hold stable while `next_stalled`=1.
- **Request issue:** `mem_req_valid`=1 when all of the following hold:
  - state is RUN;
  - `flush`=0;
  - `inflight + count - pop < FIFO_DEPTH`.
  
  This guarantees every response has a slot.
- **Request acceptance:** on `mem_req_valid && mem_req_ready`, PC advances by 4 (wraps) and `inflight` increments.
- **Response handling:**
  - Each `mem_resp_valid` decrements `inflight`.
  - If `drop`>0, the response is discarded and `drop` decrements.
  - Otherwise the response is pushed with {data, addr, error}. The entry address is taken from a parallel address queue; `mem_req_addr` is recorded at acceptance.
- **Flush (priority over everything):**
  - FIFO and address queue cleared; PC ← `flush_target`; state ← RUN.
  - `drop` ← `inflight` minus 1 if `mem_resp_valid` is high that cycle; that response is also discarded.
  - No request is issued in the flush cycle.
  - A pop in the flush cycle is irrelevant; the FIFO is cleared regardless.
- **State machine:**
  - RUN → HALT when an error response is pushed; no further requests are issued.
  - In-flight responses after the error are still received and queued.
  - HALT → RUN only on `flush` (or `rst`).
- **Counter widths:** `inflight`, `drop` and `count` are `$clog2(FIFO_DEPTH+1)` bits. None can overflow, given the issue rule.
- **Boundary cases:**
  - FIFO full with `pop`: push and pop are allowed in the same cycle.
  - FIFO empty: push goes to the head and is visible next cycle (no bypass).

## Timing
- **Reset values:**
  - Outputs: `stall_next`=1, `mem_req_valid`=0, `mem_req_addr`=`RESET_PC`, `ifetch_exception`=0.
  - `instruction`/addr outputs: don't-care.
  - Internal: PC=`RESET_PC`, `inflight`=`drop`=`count`=0, state=RUN.
- **First request after reset:** the cycle after `rst` deasserts.
- **Response to decode:** a response in cycle N is visible at the decode outputs in N+1 (`stall_next`=0).
- **Flush to decode:** flush in cycle F → request at F+1 → (1-cycle memory) response at F+2 → `stall_next`=0 at F+3.
- **Throughput:** one instruction per cycle sustained, with a 1-cycle memory and `FIFO_DEPTH`≥2.
- **Mid-operation reset:** reset mid-operation clears everything as above. Responses to requests issued before reset must not occur (the memory is reset together with this block).

## Configuration
- **`IFETCH_MISALIGN_CHECK_EN` defined:**
  - A `flush_target` with `[1:0]`≠0 issues no request.
  - One entry is pushed with `ifetch_exception`=1, `instruction_addr`=`flush_target`, data don't-care.
  - State ← HALT.
- **`IFETCH_MISALIGN_CHECK_EN` undefined:** `flush_target[1:0]` is ignored (forced to 0); there is no misalignment fault.

## Test plan
- **Reset, 1-cycle memory, `next_stalled`=0:** requests to 0x0, 0x4, 0x8… each cycle. Outputs from cycle 3 carry addr 0x0/next 0x4, then 0x4/0x8, with `stall_next`=0 continuously.
- **Backpressure:** `next_stalled`=1 for 6 cycles → at most `FIFO_DEPTH` (4) entries buffered and `mem_req_valid` drops. Head outputs hold 0x0 unchanged; on release, 0x0…0xC are delivered in order with none lost.
- **Flush with 2 in flight (3-cycle memory):** `flush_target`=0x100. The two stale responses are dropped; the first output is addr 0x100, next 0x104.
- **Error response at 0x8:** the entry has `ifetch_exception`=1; no requests are issued after it. A subsequent flush to 0x40 resumes fetching at 0x40.
- **Flush coinciding with a response and a pop:** the response is dropped, the FIFO is empty next cycle, and `drop` = `inflight`-1.
- **With `IFETCH_MISALIGN_CHECK_EN`, flush to 0x102:** a single exception entry at 0x102, zero memory requests until the next flush.
